// File: rtl/wisard_addr_gen.sv
// Serialises one pre-permuted WiSARD input sample into per-RAM address fields,
// one address per clock, framed by sop/eop, with no backpressure downstream.
module wisard_addr_gen #(
  parameter  int ADDRESS_WIDTH = 5,
  parameter  int N_RAMS        = 8,
  localparam int IN_WIDTH      = ADDRESS_WIDTH * N_RAMS,
  localparam int IDX_WIDTH     = (N_RAMS > 1) ? $clog2(N_RAMS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_WIDTH-1:0]      in_data,
  output logic                     sop,
  output logic                     eop,
  output logic                     sink_valid,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [IDX_WIDTH-1:0]     ram_idx
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_RAMS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                     state, state_nxt;
  logic [IN_WIDTH-1:0]        field_buf_p0, field_buf_nxt;
  logic [ADDRESS_WIDTH-1:0]   addr_nxt;
  logic [IDX_WIDTH-1:0]       idx_nxt, idx_inc;
  logic                       sop_nxt, eop_nxt;
  logic                       last, accept;

  assign sink_valid = (state == EMIT);
  assign last       = (ram_idx == LAST_IDX);
  // A new sample may land on the same edge the last address retires.
  assign in_ready   = !rst && !clear && (!sink_valid || last);
  assign accept     = in_valid && in_ready;
  assign idx_inc    = ram_idx + 1'b1;

  always_comb begin
    state_nxt     = state;
    field_buf_nxt = field_buf_p0;
    addr_nxt      = addr;
    idx_nxt       = ram_idx;
    sop_nxt       = 1'b0;
    eop_nxt       = 1'b0;
    if (clear) begin
      state_nxt     = IDLE;
      field_buf_nxt = '0;
      idx_nxt       = '0;
    end else if (accept) begin
      // Field 0 goes straight out; fields 1.. are parked, field 1 at the bottom.
      state_nxt     = EMIT;
      field_buf_nxt = in_data >> ADDRESS_WIDTH;
      addr_nxt      = in_data[ADDRESS_WIDTH-1:0];
      idx_nxt       = '0;
      sop_nxt       = 1'b1;
      eop_nxt       = (N_RAMS == 1);
    end else if (state == EMIT && !last) begin
      field_buf_nxt = field_buf_p0 >> ADDRESS_WIDTH;
      addr_nxt      = field_buf_p0[ADDRESS_WIDTH-1:0];
      idx_nxt       = idx_inc;
      eop_nxt       = (idx_inc == LAST_IDX);
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: serialiser registers driving the discriminator input buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      field_buf_p0 <= '0;
      addr         <= '0;
      ram_idx      <= '0;
      sop          <= 1'b0;
      eop          <= 1'b0;
    end else begin
      field_buf_p0 <= field_buf_nxt;
      addr         <= addr_nxt;
      ram_idx      <= idx_nxt;
      sop          <= sop_nxt;
      eop          <= eop_nxt;
    end
  end

endmodule

// File: tb/tb_wisard_addr_gen.sv
// Directed bench: a 4-RAM instance covers stream, back-to-back, idle, clear and
// reset cases; a 1-RAM instance covers the single-address-per-sample case.
module tb_wisard_addr_gen;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        sop, eop, sink_valid;
  logic [4:0]  addr;
  logic [1:0]  ram_idx;

  logic        in_valid1;
  logic        in_ready1;
  logic [4:0]  in_data1;
  logic        sop1, eop1, sink_valid1;
  logic [4:0]  addr1;
  logic [0:0]  ram_idx1;

  int n_cmp = 0;
  int n_bad = 0;

  wisard_addr_gen #(.ADDRESS_WIDTH(5), .N_RAMS(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sop(sop), .eop(eop), .sink_valid(sink_valid),
    .addr(addr), .ram_idx(ram_idx)
  );

  wisard_addr_gen #(.ADDRESS_WIDTH(5), .N_RAMS(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .sop(sop1), .eop(eop1), .sink_valid(sink_valid1),
    .addr(addr1), .ram_idx(ram_idx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_sv, input logic e_sop,
                         input logic e_eop, input logic [4:0] e_addr, input logic [1:0] e_idx);
    chk({tag, ".sink_valid"}, 32'(sink_valid), 32'(e_sv));
    chk({tag, ".sop"},        32'(sop),        32'(e_sop));
    chk({tag, ".eop"},        32'(eop),        32'(e_eop));
    chk({tag, ".addr"},       32'(addr),       32'(e_addr));
    chk({tag, ".ram_idx"},    32'(ram_idx),    32'(e_idx));
  endtask

  logic [4:0] exp_b2b [8];

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    in_valid1 = 1'b0; in_data1 = '0;
    exp_b2b = '{5'd4, 5'd3, 5'd2, 5'd1, 5'd8, 5'd7, 5'd6, 5'd5};

    // Reset state
    @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    chk("reset.in_ready1", 32'(in_ready1), 32'd0);
    rst = 1'b0;
    #1 chk("release.in_ready", 32'(in_ready), 32'd1);

    // Basic stream: fields 31,0,17,3
    @(negedge clk);
    in_valid = 1'b1; in_data = {5'd3, 5'd17, 5'd0, 5'd31};
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = {5'd9, 5'd9, 5'd9, 5'd9};
    @(negedge clk); chk_out("basic0", 1'b1, 1'b1, 1'b0, 5'd31, 2'd0);
    chk("basic0.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); chk_out("basic1", 1'b1, 1'b0, 1'b0, 5'd0, 2'd1);
    chk("basic1.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); chk_out("basic2", 1'b1, 1'b0, 1'b0, 5'd17, 2'd2);
    chk("basic2.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); chk_out("basic3", 1'b1, 1'b0, 1'b1, 5'd3, 2'd3);
    chk("basic3.in_ready", 32'(in_ready), 32'd1);

    // Idle gap: addr and ram_idx hold
    @(negedge clk); chk_out("idle", 1'b0, 1'b0, 1'b0, 5'd3, 2'd3);
    chk("idle.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back: two samples with in_valid held high
    in_valid = 1'b1; in_data = {5'd1, 5'd2, 5'd3, 5'd4};
    @(posedge clk); #1;
    in_data = {5'd5, 5'd6, 5'd7, 5'd8};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_out($sformatf("b2b%0d", i), 1'b1, (i % 4) == 0, (i % 4) == 3, exp_b2b[i], 2'(i % 4));
      chk($sformatf("b2b%0d.in_ready", i), 32'(in_ready), 32'((i % 4) == 3));
      if (i == 4) in_valid = 1'b0;
    end
    @(negedge clk); chk_out("b2b_end", 1'b0, 1'b0, 1'b0, 5'd5, 2'd3);

    // Clear mid-sample at ram_idx 1
    in_valid = 1'b1; in_data = {5'd9, 5'd10, 5'd11, 5'd12};
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk_out("clr0", 1'b1, 1'b1, 1'b0, 5'd12, 2'd0);
    @(negedge clk); chk_out("clr1", 1'b1, 1'b0, 1'b0, 5'd11, 2'd1);
    clear = 1'b1; in_valid = 1'b1; in_data = {5'd30, 5'd30, 5'd30, 5'd30};
    #1 chk("clr.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); chk_out("clr2", 1'b0, 1'b0, 1'b0, 5'd11, 2'd0);
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk_out("clr3", 1'b0, 1'b0, 1'b0, 5'd11, 2'd0);
    in_valid = 1'b1; in_data = {5'd13, 5'd14, 5'd15, 5'd16};
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk_out("clr_new0", 1'b1, 1'b1, 1'b0, 5'd16, 2'd0);
    @(negedge clk); chk_out("clr_new1", 1'b1, 1'b0, 1'b0, 5'd15, 2'd1);
    @(negedge clk); chk_out("clr_new2", 1'b1, 1'b0, 1'b0, 5'd14, 2'd2);
    @(negedge clk); chk_out("clr_new3", 1'b1, 1'b0, 1'b1, 5'd13, 2'd3);

    // Reset mid-sample at ram_idx 2
    @(negedge clk);
    in_valid = 1'b1; in_data = {5'd20, 5'd21, 5'd22, 5'd23};
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk_out("rst0", 1'b1, 1'b1, 1'b0, 5'd23, 2'd0);
    @(negedge clk);
    @(negedge clk); chk_out("rst2", 1'b1, 1'b0, 1'b0, 5'd21, 2'd2);
    #2 rst = 1'b1;
    #1 chk_out("rst_async", 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    chk("rst_async.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_rel.in_ready", 32'(in_ready), 32'd1);
    chk_out("rst_rel", 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    in_valid = 1'b1; in_data = {5'd4, 5'd5, 5'd6, 5'd7};
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk_out("rst_new0", 1'b1, 1'b1, 1'b0, 5'd7, 2'd0);
    @(negedge clk); chk_out("rst_new1", 1'b1, 1'b0, 1'b0, 5'd6, 2'd1);
    @(negedge clk); chk_out("rst_new2", 1'b1, 1'b0, 1'b0, 5'd5, 2'd2);
    @(negedge clk); chk_out("rst_new3", 1'b1, 1'b0, 1'b1, 5'd4, 2'd3);

    // Single-RAM instance: samples 7, 0, 31 back to back
    @(negedge clk);
    chk("n1_idle.in_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1; in_data1 = 5'd7;
    @(negedge clk);
    chk("n1_s0", 32'({sink_valid1, sop1, eop1}), 32'b111);
    chk("n1_s0.addr", 32'(addr1), 32'd7);
    chk("n1_s0.in_ready", 32'(in_ready1), 32'd1);
    in_data1 = 5'd0;
    @(negedge clk);
    chk("n1_s1", 32'({sink_valid1, sop1, eop1}), 32'b111);
    chk("n1_s1.addr", 32'(addr1), 32'd0);
    in_data1 = 5'd31;
    @(negedge clk);
    chk("n1_s2", 32'({sink_valid1, sop1, eop1}), 32'b111);
    chk("n1_s2.addr", 32'(addr1), 32'd31);
    chk("n1_s2.ram_idx", 32'(ram_idx1), 32'd0);
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("n1_end", 32'({sink_valid1, sop1, eop1}), 32'b000);
    chk("n1_end.addr", 32'(addr1), 32'd31);
    chk("n1_end.in_ready", 32'(in_ready1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
